animador_mensaje: RTL and testbench
===================================

# animador_mensaje

Message animation sequencer that generates the 8-digit segment frame for the display multiplexer. On a start pulse it captures a message of up to 8 character patterns, scrolls it into the display from the right, holds it with blinking, scrolls it out to the left, and then either repeats or stops. Its outputs drive the multiplexer stage directly:

- `ventana` supplies the per-digit active-low segment words.
- `activo` drives the multiplexer `enable`.

## Interface

**Parameters**

- `LONG_MSG`, default 5: message length in characters; legal range 1..8.
- `DIV_PASO`, default 25_000_000: clk cycles per animation step (4 Hz at 100 MHz); must be ≥ 2.
- `N_MOSTRAR`, default 8: number of steps spent in the hold/blink phase; must be ≥ 1.

**Ports**

- `clk` input 1: system clock. The block has one clock; everything is on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `iniciar` input 1: start request. Acts on its level each cycle while in INACTIVO.
- `pausa` input 1: level. While high, the prescaler and all step counters freeze.
- `ciclico` input 1: sampled at the end of SALIDA. 1 = repeat, 0 = stop.
- `mensaje` input 7*LONG_MSG: character patterns, active-low segments g..a. Character 0 (first to appear, leftmost) is `mensaje[6:0]`; character k is `mensaje[7k+6:7k]`.
- `ventana` output 56: frame. Digit 7 (leftmost) is `[55:49]`, digit 0 (rightmost) is `[6:0]`. Active-low; blank = 7'b1111111.
- `activo` output 1: high in every state except INACTIVO.
- `estado` output 2: 0 = INACTIVO, 1 = ENTRADA, 2 = MOSTRAR, 3 = SALIDA.
- `paso` output 1: one-cycle pulse on each animation step.
- `hecho` output 1: one-cycle pulse when the animation ends without repeating.

## Operation

**Reset values:**
- `ventana` = all ones.
- `estado` = INACTIVO.
- `activo`, `paso`, `hecho` = 0.
- Prescaler, character index and phase counter = 0.
- Captured message = all ones.

**Prescaler:**
- Counts 0..DIV_PASO-1 only while `estado` ≠ INACTIVO and `pausa` = 0.
- The step event is counter = DIV_PASO-1. On that cycle the counter wraps to 0 and `paso` is registered high for one cycle.

**Internal frame register:**
- A step shifts it left by one digit: new frame = {old[48:0], ins}.

**INACTIVO:**
- If `iniciar` = 1: capture `mensaje`, clear the frame to blank, clear prescaler and counters, go to ENTRADA.
- Otherwise hold.

**ENTRADA:**
- On each step, `ins` = captured character `idx`, then `idx` increments.
- After the step that inserts character LONG_MSG-1, go to MOSTRAR with phase = 0.
- At that point the message occupies digits LONG_MSG-1..0.

**MOSTRAR:**
- No shifting.
- Each step increments phase. After the N_MOSTRAR-th step, go to SALIDA with phase = 0.
- `ventana` is forced to all ones while phase[0] = 1; otherwise it shows the frame.

**SALIDA:**
- On each step, `ins` = blank and phase increments.
- After the 8th step the frame is all blank. Then:
  - If `ciclico` = 1: go to ENTRADA with `idx` = 0, reusing the captured message.
  - Otherwise: go to INACTIVO and pulse `hecho`.

**General rules:**
- In every state except the MOSTRAR blink phase, `ventana` equals the frame register.
- `iniciar` is ignored outside INACTIVO; `mensaje` changes after capture have no effect.
- `pausa` high on a step-event cycle suppresses that step. The step occurs on the first cycle after `pausa` falls at which the counter is at DIV_PASO-1; the count is unchanged across the pause.
- `reset` asserted mid-animation returns all outputs to their reset values immediately (asynchronous reset); no `hecho` pulse is produced.

## Timing

- All outputs are registered.
- `iniciar` sampled at edge t:
  - `activo` = 1 and `estado` = 1 from t+1.
  - First step event at edge t+DIV_PASO.
  - `paso` and the shifted `ventana` are visible after that edge.
- Step period is exactly DIV_PASO cycles when `pausa` = 0.
- The state change and the frame update happen on the same edge as the step that causes them.
- Full animation length is LONG_MSG + N_MOSTRAR + 8 steps.
- `hecho` rises on the same edge where `estado` returns to 0 and `activo` falls.
- A new `iniciar` is accepted on the first cycle in INACTIVO, i.e. the edge after `hecho`.

## Test plan

Parameters for all cases: LONG_MSG = 5, DIV_PASO = 4, N_MOSTRAR = 4. Message D, A, V, I, D = 0100001, 0001000, 1100011, 1111011, 0100001.

- **Reset mid-ENTRADA.** Apply `reset` after 2 steps → `ventana` = all ones, `estado` = 0, `activo` = 0 within the same cycle; no `paso`, no `hecho`.
- **Single run, `ciclico` = 0.** Pulse `iniciar` → `paso` every 4 cycles. After step 1, digit 0 = D. After step 5, digits 4..0 = D, A, V, I, D and `estado` = 2. MOSTRAR steps show visible / blank / visible / blank. After 8 SALIDA steps, `ventana` = all ones, `hecho` pulses once, `estado` = 0. Total 17 steps = 68 cycles after `iniciar`.
- **Pause.** Hold `pausa` for 10 cycles during ENTRADA → no `paso` and `ventana` unchanged during the pause; the step spacing resumes with the prescaler count preserved.
- **Cyclic repeat.** Run with `ciclico` = 1 → after the SALIDA step 8, `estado` goes 3 → 1, no `hecho`, and the next step inserts D again. Drop `ciclico` during the second pass → `hecho` at the end of that pass.
- **Start ignored while active.** Pulse `iniciar` and change `mensaje` mid-animation → no restart; the original characters continue. `iniciar` held high continuously → immediate restart on the cycle after `hecho`.

Source files
------------

// File: rtl/animador_mensaje.sv
// Message animation sequencer: scrolls a captured message into an 8-digit
// active-low segment frame from the right, holds it with blinking, scrolls it
// out to the left, then repeats or stops.
module animador_mensaje #(
    parameter int LONG_MSG  = 5,
    parameter int DIV_PASO  = 25_000_000,
    parameter int N_MOSTRAR = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  iniciar,
    input  logic                  pausa,
    input  logic                  ciclico,
    input  logic [7*LONG_MSG-1:0] mensaje,
    output logic [55:0]           ventana,
    output logic                  activo,
    output logic [1:0]            estado,
    output logic                  paso,
    output logic                  hecho
);

    localparam logic [1:0] INACTIVO = 2'd0;
    localparam logic [1:0] ENTRADA  = 2'd1;
    localparam logic [1:0] MOSTRAR  = 2'd2;
    localparam logic [1:0] SALIDA   = 2'd3;

    localparam int W_PRESC = $clog2(DIV_PASO);
    // Phase counter must reach both N_MOSTRAR-1 and the 8 scroll-out steps.
    localparam int N_FASE  = (N_MOSTRAR > 8) ? N_MOSTRAR : 8;
    localparam int W_FASE  = $clog2(N_FASE);

    localparam logic [W_PRESC-1:0] PRESC_FIN   = W_PRESC'(DIV_PASO - 1);
    localparam logic [W_FASE-1:0]  FASE_FIN_M  = W_FASE'(N_MOSTRAR - 1);
    localparam logic [W_FASE-1:0]  FASE_FIN_S  = W_FASE'(7);
    localparam logic [2:0]         IDX_FIN     = 3'(LONG_MSG - 1);
    localparam logic [6:0]         BLANCO      = 7'b1111111;

    logic [1:0]         r_estado;
    logic [W_PRESC-1:0] r_presc;
    logic [2:0]         r_idx;
    logic [W_FASE-1:0]  r_fase;
    logic [55:0]        r_msg;
    logic [55:0]        r_frame;
    logic [55:0]        r_ventana;
    logic               r_activo;
    logic               r_paso;
    logic               r_hecho;

    logic [1:0]         w_estado_n;
    logic [W_PRESC-1:0] w_presc_n;
    logic [2:0]         w_idx_n;
    logic [W_FASE-1:0]  w_fase_n;
    logic [55:0]        w_msg_n;
    logic [55:0]        w_frame_n;
    logic [55:0]        w_ventana_n;
    logic               w_activo_n;
    logic               w_paso_n;
    logic               w_hecho_n;

    logic               w_evento;
    logic [5:0]         w_base;
    logic [6:0]         w_char;

    // Step event: prescaler terminal count while running and not paused
    assign w_evento = (r_estado != INACTIVO) && !pausa && (r_presc == PRESC_FIN);

    // Character idx of the captured message (base = 7 * idx)
    assign w_base = {r_idx, 3'b000} - {3'b000, r_idx};
    assign w_char = r_msg[w_base +: 7];

    // Next-state: prescaler, sequencer FSM, frame shifting and output words
    always_comb begin
        w_estado_n = r_estado;
        w_presc_n  = r_presc;
        w_idx_n    = r_idx;
        w_fase_n   = r_fase;
        w_msg_n    = r_msg;
        w_frame_n  = r_frame;
        w_hecho_n  = 1'b0;
        w_paso_n   = w_evento;

        if ((r_estado != INACTIVO) && !pausa) begin
            w_presc_n = w_evento ? '0 : r_presc + 1'b1;
        end

        case (r_estado)
            INACTIVO: begin
                if (iniciar) begin
                    // Unused character slots stay blank
                    w_msg_n                 = '1;
                    w_msg_n[7*LONG_MSG-1:0] = mensaje;
                    w_frame_n               = '1;
                    w_presc_n               = '0;
                    w_idx_n                 = '0;
                    w_fase_n                = '0;
                    w_estado_n              = ENTRADA;
                end
            end
            ENTRADA: begin
                if (w_evento) begin
                    w_frame_n = {r_frame[48:0], w_char};
                    if (r_idx == IDX_FIN) begin
                        w_estado_n = MOSTRAR;
                        w_fase_n   = '0;
                    end else begin
                        w_idx_n = r_idx + 1'b1;
                    end
                end
            end
            MOSTRAR: begin
                if (w_evento) begin
                    if (r_fase == FASE_FIN_M) begin
                        w_estado_n = SALIDA;
                        w_fase_n   = '0;
                    end else begin
                        w_fase_n = r_fase + 1'b1;
                    end
                end
            end
            SALIDA: begin
                if (w_evento) begin
                    w_frame_n = {r_frame[48:0], BLANCO};
                    if (r_fase == FASE_FIN_S) begin
                        w_fase_n = '0;
                        if (ciclico) begin
                            w_estado_n = ENTRADA;
                            w_idx_n    = '0;
                        end else begin
                            w_estado_n = INACTIVO;
                            w_hecho_n  = 1'b1;
                        end
                    end else begin
                        w_fase_n = r_fase + 1'b1;
                    end
                end
            end
            default: w_estado_n = INACTIVO;
        endcase

        // Odd hold phases blank the display
        w_ventana_n = ((w_estado_n == MOSTRAR) && w_fase_n[0]) ? '1 : w_frame_n;
        w_activo_n  = (w_estado_n != INACTIVO);
    end

    // State and registered outputs, asynchronous active-high reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado  <= INACTIVO;
            r_presc   <= '0;
            r_idx     <= '0;
            r_fase    <= '0;
            r_msg     <= '1;
            r_frame   <= '1;
            r_ventana <= '1;
            r_activo  <= 1'b0;
            r_paso    <= 1'b0;
            r_hecho   <= 1'b0;
        end else begin
            r_estado  <= w_estado_n;
            r_presc   <= w_presc_n;
            r_idx     <= w_idx_n;
            r_fase    <= w_fase_n;
            r_msg     <= w_msg_n;
            r_frame   <= w_frame_n;
            r_ventana <= w_ventana_n;
            r_activo  <= w_activo_n;
            r_paso    <= w_paso_n;
            r_hecho   <= w_hecho_n;
        end
    end

    assign ventana = r_ventana;
    assign activo  = r_activo;
    assign estado  = r_estado;
    assign paso    = r_paso;
    assign hecho   = r_hecho;

endmodule

// File: tb/tb_animador_mensaje.sv
// Directed bench for animador_mensaje with LONG_MSG=5, DIV_PASO=4, N_MOSTRAR=4.
module tb_animador_mensaje;

    localparam int LONG_MSG  = 5;
    localparam int DIV_PASO  = 4;
    localparam int N_MOSTRAR = 4;

    localparam logic [6:0] CB = 7'b1111111;
    localparam logic [6:0] CD = 7'b0100001;
    localparam logic [6:0] CA = 7'b0001000;
    localparam logic [6:0] CV = 7'b1100011;
    localparam logic [6:0] CI = 7'b1111011;
    localparam logic [6:0] CE = 7'b0000110;

    localparam logic [34:0] MSG     = {CD, CI, CV, CA, CD};
    localparam logic [34:0] MSG_ALT = {CE, CE, CE, CE, CE};

    typedef struct {
        logic        cic;
        logic [1:0]  est;
        logic [55:0] ven;
        logic        hecho;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        iniciar;
    logic        pausa;
    logic        ciclico;
    logic [34:0] mensaje;
    logic [55:0] ventana;
    logic        activo;
    logic [1:0]  estado;
    logic        paso;
    logic        hecho;

    int   checks;
    int   errors;
    vec_t vec [17];
    vec_t w;

    animador_mensaje #(
        .LONG_MSG (LONG_MSG),
        .DIV_PASO (DIV_PASO),
        .N_MOSTRAR(N_MOSTRAR)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .iniciar(iniciar),
        .pausa  (pausa),
        .ciclico(ciclico),
        .mensaje(mensaje),
        .ventana(ventana),
        .activo (activo),
        .estado (estado),
        .paso   (paso),
        .hecho  (hecho)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One full step interval: three quiet cycles then the step edge
    task automatic apply_vec(input vec_t v, input string tag);
        logic ruido;
        ciclico = v.cic;
        ruido   = 1'b0;
        for (int c = 0; c < DIV_PASO - 1; c++) begin
            tick();
            if (paso !== 1'b0 || hecho !== 1'b0) ruido = 1'b1;
        end
        chk({tag, ".quiet"}, 64'(ruido), 64'(0));
        tick();
        chk({tag, ".paso"}, 64'(paso), 64'(1));
        chk({tag, ".estado"}, 64'(estado), 64'(v.est));
        chk({tag, ".ventana"}, 64'(ventana), 64'(v.ven));
        chk({tag, ".hecho"}, 64'(hecho), 64'(v.hecho));
        chk({tag, ".activo"}, 64'(activo), 64'(v.est != 2'd0));
    endtask

    task automatic start(input string tag);
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk({tag, ".start_estado"}, 64'(estado), 64'(1));
        chk({tag, ".start_activo"}, 64'(activo), 64'(1));
        chk({tag, ".start_ventana"}, 64'(ventana), {8'h00, {8{CB}}});
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        iniciar = 1'b0;
        pausa   = 1'b0;
        ciclico = 1'b0;
        mensaje = MSG;

        vec[0]  = '{1'b0, 2'd1, {{7{CB}}, CD}, 1'b0};
        vec[1]  = '{1'b0, 2'd1, {{6{CB}}, CD, CA}, 1'b0};
        vec[2]  = '{1'b0, 2'd1, {{5{CB}}, CD, CA, CV}, 1'b0};
        vec[3]  = '{1'b0, 2'd1, {{4{CB}}, CD, CA, CV, CI}, 1'b0};
        vec[4]  = '{1'b0, 2'd2, {{3{CB}}, CD, CA, CV, CI, CD}, 1'b0};
        vec[5]  = '{1'b0, 2'd2, {8{CB}}, 1'b0};
        vec[6]  = '{1'b0, 2'd2, {{3{CB}}, CD, CA, CV, CI, CD}, 1'b0};
        vec[7]  = '{1'b0, 2'd2, {8{CB}}, 1'b0};
        vec[8]  = '{1'b0, 2'd3, {{3{CB}}, CD, CA, CV, CI, CD}, 1'b0};
        vec[9]  = '{1'b0, 2'd3, {{2{CB}}, CD, CA, CV, CI, CD, CB}, 1'b0};
        vec[10] = '{1'b0, 2'd3, {CB, CD, CA, CV, CI, CD, CB, CB}, 1'b0};
        vec[11] = '{1'b0, 2'd3, {CD, CA, CV, CI, CD, {3{CB}}}, 1'b0};
        vec[12] = '{1'b0, 2'd3, {CA, CV, CI, CD, {4{CB}}}, 1'b0};
        vec[13] = '{1'b0, 2'd3, {CV, CI, CD, {5{CB}}}, 1'b0};
        vec[14] = '{1'b0, 2'd3, {CI, CD, {6{CB}}}, 1'b0};
        vec[15] = '{1'b0, 2'd3, {CD, {7{CB}}}, 1'b0};
        vec[16] = '{1'b0, 2'd0, {8{CB}}, 1'b1};

        // Reset values
        tick();
        tick();
        chk("rst.ventana", 64'(ventana), {8'h00, {8{CB}}});
        chk("rst.estado", 64'(estado), 64'(0));
        chk("rst.activo", 64'(activo), 64'(0));
        chk("rst.paso", 64'(paso), 64'(0));
        chk("rst.hecho", 64'(hecho), 64'(0));
        reset = 1'b0;
        tick();
        chk("idle.estado", 64'(estado), 64'(0));

        // Reset mid-ENTRADA: outputs clear without waiting for an edge
        start("rm");
        apply_vec(vec[0], "rm0");
        apply_vec(vec[1], "rm1");
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("rm.ventana", 64'(ventana), {8'h00, {8{CB}}});
        chk("rm.estado", 64'(estado), 64'(0));
        chk("rm.activo", 64'(activo), 64'(0));
        chk("rm.paso", 64'(paso), 64'(0));
        tick();
        reset = 1'b0;
        begin
            logic ruido;
            ruido = 1'b0;
            for (int c = 0; c < 12; c++) begin
                tick();
                if (paso !== 1'b0 || hecho !== 1'b0 || estado !== 2'd0) ruido = 1'b1;
            end
            chk("rm.after", 64'(ruido), 64'(0));
        end

        // Single run, ciclico = 0: 17 steps, 68 cycles
        start("run");
        for (int i = 0; i < 17; i++) apply_vec(vec[i], $sformatf("run%0d", i));
        tick();
        chk("run.hecho_once", 64'(hecho), 64'(0));
        chk("run.idle", 64'(estado), 64'(0));

        // Pause for 10 cycles during ENTRADA; prescaler count preserved
        start("pz");
        apply_vec(vec[0], "pz0");
        tick();
        pausa = 1'b1;
        begin
            logic ruido;
            ruido = 1'b0;
            for (int c = 0; c < 10; c++) begin
                tick();
                if (paso !== 1'b0 || ventana !== vec[0].ven || estado !== 2'd1) ruido = 1'b1;
            end
            chk("pz.frozen", 64'(ruido), 64'(0));
        end
        pausa = 1'b0;
        tick();
        chk("pz.resume1", 64'(paso), 64'(0));
        tick();
        chk("pz.resume2", 64'(paso), 64'(0));
        tick();
        chk("pz.step", 64'(paso), 64'(1));
        chk("pz.ventana", 64'(ventana), 64'(vec[1].ven));
        for (int i = 2; i < 17; i++) apply_vec(vec[i], $sformatf("pz%0d", i));

        // Cyclic repeat, then drop ciclico during the second pass
        start("cy");
        for (int i = 0; i < 16; i++) begin
            w     = vec[i];
            w.cic = 1'b1;
            apply_vec(w, $sformatf("cy%0d", i));
        end
        w = '{1'b1, 2'd1, {8{CB}}, 1'b0};
        apply_vec(w, "cy_wrap");
        for (int i = 0; i < 17; i++) apply_vec(vec[i], $sformatf("cy2_%0d", i));

        // Start and message change ignored while active; held start restarts
        start("ig");
        for (int i = 0; i < 3; i++) apply_vec(vec[i], $sformatf("ig%0d", i));
        iniciar = 1'b1;
        mensaje = MSG_ALT;
        for (int i = 3; i < 17; i++) apply_vec(vec[i], $sformatf("ig%0d", i));
        tick();
        chk("ig.restart_estado", 64'(estado), 64'(1));
        chk("ig.restart_activo", 64'(activo), 64'(1));
        chk("ig.restart_ventana", 64'(ventana), {8'h00, {8{CB}}});
        w = '{1'b0, 2'd1, {{7{CB}}, CE}, 1'b0};
        apply_vec(w, "ig_new0");
        iniciar = 1'b0;
        reset   = 1'b1;
        tick();
        reset   = 1'b0;
        mensaje = MSG;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
